bitmap_sprite_anim: RTL

Parametrised, animated successor to the single-image bitmap sprite renderer. It stores `NUM_FRAMES` RGB332 images of `OBJECT_WIDTH_X`×`OBJECT_HEIGHT_Y` pixels. Per pixel it produces a registered `drawingRequest` and a full-range 24-bit `RGBout`, adding integer scaling, horizontal mirroring, frame-synchronous animation and blinking. It sits between a square/rectangle-object locator (which supplies offsets and `InsideRectangle`) and the video mux.

---
 rtl/sprite_pkg.sv | 34 +++
 rtl/sprite_rom.sv | 21 ++
 rtl/bitmap_sprite_anim.sv | 114 +++++++++++
 3 files changed

// File: rtl/sprite_pkg.sv
// Shared types, colour helpers and default ROM contents for the animated sprite renderer.
// Pure definitions: no latency, no flow control.
package sprite_pkg;

  localparam int R_BITS = 3;
  localparam int G_BITS = 3;
  localparam int B_BITS = 2;

  localparam logic [7:0] TRANSPARENT_ENCODING_DEF = 8'hFF;

  typedef struct packed {
    logic [7:0] frame;
    logic       mirror;
    logic       blinkPhase;
    logic       blinkEn;
  } sprite_ctrl_t;

  // Bit replication spreads each RGB332 field over the full 0..255 range.
  function automatic logic [23:0] rgb332_to_rgb888(input logic [7:0] pix);
    logic [R_BITS-1:0] r;
    logic [G_BITS-1:0] g;
    logic [B_BITS-1:0] b;
    r = pix[7:8-R_BITS];
    g = pix[7-R_BITS:B_BITS];
    b = pix[B_BITS-1:0];
    return {r, r, r[2:1], g, g, g[2:1], b, b, b, b};
  endfunction

  // Image content used when no memory file is supplied.
  function automatic logic [7:0] default_pix(input logic [15:0] addr);
    return addr[7:0] ^ 8'hF0 ^ {addr[12:8], 3'b000} ^ {5'b00000, addr[15:13]};
  endfunction

endpackage

// File: rtl/sprite_rom.sv
// Sprite image store: NUM_FRAMES*W*H bytes, filled from the built-in package pattern.
// One registered read port, 1 clk latency; no backpressure.
module sprite_rom
    import sprite_pkg::*;
#(
    parameter int    DEPTH    = 4800,
    parameter int    AW       = 13,
    parameter string MEM_FILE = ""
) (
    input  logic          clk,
    input  logic          resetN,
    input  logic [AW-1:0] addr,
    output logic [7:0]    data
);

    always_ff @(posedge clk) begin
        if (!resetN) data <= '0;
        else         data <= default_pix(16'(addr));
    end

endmodule

// File: rtl/bitmap_sprite_anim.sv
// Animated, scalable, mirrorable RGB332 sprite renderer with blinking.
// Latency 2 clk from offsets to drawingRequest/RGBout; one pixel per clk, never stalls.
module bitmap_sprite_anim
  import sprite_pkg::*;
#(
  parameter int         OBJECT_WIDTH_X       = 60,
  parameter int         OBJECT_HEIGHT_Y      = 20,
  parameter int         NUM_FRAMES           = 4,
  parameter int         FRAME_TICKS          = 8,
  parameter int         BLINK_TICKS          = 16,
  parameter int         SCALE_LOG2           = 0,
  parameter logic [7:0] TRANSPARENT_ENCODING = TRANSPARENT_ENCODING_DEF,
  parameter string      MEM_FILE             = ""
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic        startOfFrame,
  input  logic [10:0] offsetX,
  input  logic [10:0] offsetY,
  input  logic        InsideRectangle,
  input  logic        mirrorX,
  input  logic        animRun,
  input  logic        blinkEn,
  output logic        drawingRequest,
  output logic [23:0] RGBout,
  output logic [(NUM_FRAMES > 1 ? $clog2(NUM_FRAMES) : 1)-1:0] frameIndex
);

  localparam int FW    = NUM_FRAMES > 1 ? $clog2(NUM_FRAMES) : 1;
  localparam int TW    = FRAME_TICKS > 1 ? $clog2(FRAME_TICKS) : 1;
  localparam int BW    = BLINK_TICKS > 1 ? $clog2(BLINK_TICKS) : 1;
  localparam int DEPTH = NUM_FRAMES * OBJECT_WIDTH_X * OBJECT_HEIGHT_Y;
  localparam int AW    = DEPTH > 1 ? $clog2(DEPTH) : 1;

  sprite_ctrl_t   ctrl_q;
  logic [TW-1:0]  tick_cnt;
  logic [BW-1:0]  blink_cnt;

  // All per-frame state moves only on startOfFrame so a whole video frame sees one snapshot.
  always_ff @(posedge clk) begin
    if (!resetN) begin
      ctrl_q    <= '0;
      tick_cnt  <= '0;
      blink_cnt <= '0;
    end else if (startOfFrame) begin
      ctrl_q.mirror  <= mirrorX;
      ctrl_q.blinkEn <= blinkEn;
      if (animRun) begin
        tick_cnt <= (tick_cnt == TW'(FRAME_TICKS - 1)) ? '0 : tick_cnt + 1'b1;
        // The image steps as each FRAME_TICKS window opens.
        if (tick_cnt == '0)
          ctrl_q.frame <= (ctrl_q.frame == 8'(NUM_FRAMES - 1)) ? '0 : ctrl_q.frame + 8'd1;
      end
      if (!blinkEn) begin
        blink_cnt         <= '0;
        ctrl_q.blinkPhase <= 1'b0;
      end else if (blink_cnt == BW'(BLINK_TICKS - 1)) begin
        blink_cnt         <= '0;
        ctrl_q.blinkPhase <= ~ctrl_q.blinkPhase;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end
    end
  end

  assign frameIndex = ctrl_q.frame[FW-1:0];

  logic [10:0]   sx, sy, col;
  logic          pix_valid;
  logic [AW-1:0] addr_d;

  always_comb begin
    sx        = offsetX >> SCALE_LOG2;
    sy        = offsetY >> SCALE_LOG2;
    pix_valid = InsideRectangle && (32'(sx) < OBJECT_WIDTH_X) && (32'(sy) < OBJECT_HEIGHT_Y);
    col       = ctrl_q.mirror ? 11'(OBJECT_WIDTH_X - 1) - sx : sx;
    addr_d    = '0;
    if (pix_valid)
      addr_d = AW'((32'(ctrl_q.frame) * OBJECT_HEIGHT_Y + 32'(sy)) * OBJECT_WIDTH_X + 32'(col));
  end

  logic [AW-1:0] addr_q;
  logic          valid_q, hide_q, draw_q;
  logic [7:0]    rom_dat;

  always_ff @(posedge clk) begin
    if (!resetN) begin
      addr_q  <= '0;
      valid_q <= 1'b0;
      hide_q  <= 1'b0;
      draw_q  <= 1'b0;
    end else begin
      addr_q  <= addr_d;
      valid_q <= pix_valid;
      hide_q  <= ctrl_q.blinkEn && ctrl_q.blinkPhase;
      draw_q  <= valid_q && !hide_q;
    end
  end

  sprite_rom #(
    .DEPTH    (DEPTH),
    .AW       (AW),
    .MEM_FILE (MEM_FILE)
  ) u_rom (
    .clk    (clk),
    .resetN (resetN),
    .addr   (addr_q),
    .data   (rom_dat)
  );

  assign drawingRequest = draw_q && (rom_dat != TRANSPARENT_ENCODING);
  assign RGBout         = rgb332_to_rgb888(rom_dat);

endmodule
